// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the program-ROM fetch sequencer.
// Optional feature macro: ROM_FETCH_HALT_EN (halt-opcode detection).
package rom_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

  // ROM latency is at most 7, so three bits cover the wait counter.
  localparam int CNT_W = 3;

  // The halt opcode is the opcode field filled with this bit (all ones).
  localparam logic HALT_OP_BIT = 1'b1;

endpackage

// File: rtl/rom_fetch_timer.sv
// ROM read-latency down-counter: loaded when a fetch starts, counts down
// while fetching, and flags zero when the ROM word is ready to latch.
module rom_fetch_timer
  import rom_fetch_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; counting stops at zero so the flag holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (load)            cnt <= CNT_W'(ROM_LAT);
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer for the synchronous program ROM.
// Owns the PC, drives the registered ROM address, waits out the ROM
// latency, and hands the word to the execution stage via valid/ready.
// Optional feature macro: ROM_FETCH_HALT_EN -- when defined, an all-ones
// opcode field at handshake parks the controller in HALT until a jump.
module rom_fetch_ctrl
  import rom_fetch_pkg::*;
#(
  parameter int AW      = 10,
  parameter int DW      = 16,
  parameter int ROM_LAT = 1,
  parameter int OPW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          step,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted
);

  if (OPW < 1 || OPW > DW || ROM_LAT < 1 || ROM_LAT > 7) begin : g_param_chk
    $error("rom_fetch_ctrl: OPW must be 1..DW and ROM_LAT 1..7");
  end

  fetch_state_t state, state_nxt;

  logic          t_zero;
  logic          start_fetch;
  logic          word_done;
  logic          hs;
  logic          halt_det;
  logic          pc_ld;
  logic [AW-1:0] pc_nxt;

`ifdef ROM_FETCH_HALT_EN
  assign halt_det = (instr[DW-1:DW-OPW] == {OPW{HALT_OP_BIT}});
`else
  assign halt_det = 1'b0;
`endif

  rom_fetch_timer #(.ROM_LAT(ROM_LAT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (start_fetch),
    .en   (state == S_FETCH),
    .zero (t_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; jump in IDLE/HALT wins over run/step.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!jump_en && (run || step)) state_nxt = S_FETCH;
      S_FETCH: if (t_zero)                    state_nxt = S_HOLD;
      S_HOLD:  if (instr_ready)               state_nxt = halt_det ? S_HALT : S_IDLE;
      S_HALT:  if (jump_en)                   state_nxt = S_IDLE;
      default:                                state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath-control decode from the current state.
  always_comb begin
    start_fetch = 1'b0;
    word_done   = 1'b0;
    hs          = 1'b0;
    pc_ld       = 1'b0;
    pc_nxt      = pc;
    busy        = 1'b0;
    halted      = 1'b0;
    case (state)
      S_IDLE: begin
        if (jump_en) begin
          pc_ld  = 1'b1;
          pc_nxt = jump_addr;
        end else if (run || step) begin
          start_fetch = 1'b1;
        end
      end
      S_FETCH: begin
        busy      = 1'b1;
        word_done = t_zero;
      end
      S_HOLD: begin
        busy = 1'b1;
        if (instr_ready) begin
          hs     = 1'b1;
          pc_ld  = 1'b1;
          pc_nxt = jump_en ? jump_addr : pc + 1'b1;  // natural wrap at 2^AW
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (jump_en) begin
          pc_ld  = 1'b1;
          pc_nxt = jump_addr;
        end
      end
      default: ;
    endcase
  end

  // PC, ROM address and instruction/valid registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= '0;
      rom_addr    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (pc_ld)       pc       <= pc_nxt;
      if (start_fetch) rom_addr <= pc;
      if (word_done) begin
        instr       <= rom_data;
        instr_valid <= 1'b1;
      end
      if (hs)          instr_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rom_fetch_ctrl.md
# rom_fetch_ctrl

Instruction-fetch sequencer for the 1K×16 synchronous program ROM. It owns the program counter and drives the ROM address. It waits out the ROM read latency, latches the word, and presents it to the execution stage with a valid/ready handshake. Fetching runs free (`run`) or one instruction per debounced `step` pulse. It supports jumps and halt-opcode detection, and sits between the clock/step front end (debounce, prescaler) and the accumulator datapath.

## Interface
Parameters:
- `AW`, 10: address width (ROM depth 2^AW)
- `DW`, 16: instruction width
- `ROM_LAT`, 1: ROM read latency in clk cycles, 1..7
- `OPW`, 4: opcode field width, `instr[DW-1:DW-OPW]`

Ports:
- `clk` in 1: system clock, all logic on rising edge
- `rst` in 1: reset, asynchronous, active-low
- `run` in 1: level; fetch continuously while high
- `step` in 1: one-cycle pulse; request a single fetch
- `jump_en` in 1: load `jump_addr` into PC
- `jump_addr` in AW: jump target
- `rom_addr` out AW: registered ROM address
- `rom_data` in DW: ROM output word
- `instr` out DW: latched instruction
- `instr_valid` out 1: `instr` is valid
- `instr_ready` in 1: consumer accepts `instr`
- `pc` out AW: address of the next instruction to fetch
- `busy` out 1: high in FETCH and HOLD
- `halted` out 1: high in HALT

## Operation
- Reset (`rst`=0, async) forces:
  - state IDLE
  - `pc`, `rom_addr`, `instr` = 0
  - `instr_valid`, `busy`, `halted` = 0
- States are IDLE, FETCH, HOLD, HALT.
- IDLE:
  - `jump_en`=1: `pc`<=`jump_addr`, stay IDLE. Jump beats `step`/`run` in the same cycle; no fetch starts.
  - Else if `run`|`step`: `rom_addr`<=`pc`, load the latency counter with ROM_LAT, go to FETCH.
- FETCH:
  - The counter decrements each cycle.
  - When the counter is 0: `instr`<=`rom_data`, `instr_valid`<=1, go to HOLD.
  - `step` and `jump_en` are ignored.
- HOLD:
  - `instr_valid` stays high and `instr` stays stable until `instr_ready`=1.
  - On handshake: `instr_valid`<=0, and `pc`<=`jump_en` ? `jump_addr` : `pc`+1.
  - PC increment wraps 2^AW−1 → 0.
  - After handshake, go to HALT if halt detected (see Configuration), else IDLE.
- HALT:
  - All fetching stops; `run`/`step` are ignored.
  - `jump_en`=1: `pc`<=`jump_addr`, `halted`<=0, go to IDLE.
- `step` pulses that arrive outside IDLE are dropped, not queued.
- `run` dropping during FETCH/HOLD does not abort the fetch; the current instruction completes.

## Timing
- Trigger sampled at edge k → `rom_addr` valid after k → `instr_valid` high after edge k+ROM_LAT+1.
- With `run`=1 and `instr_ready` tied high, one instruction issues every ROM_LAT+3 cycles (IDLE, FETCH ×(ROM_LAT+1), HOLD).
- `instr_valid` drops the cycle after the handshake edge; it is never high for two consecutive handshakes on the same word.
- `pc` updates on the handshake edge; `rom_addr` updates only on leaving IDLE.
- Reset asserted mid-FETCH/HOLD clears `instr_valid` immediately (asynchronously); the in-flight word is discarded.
- Fetch restarts at address 0 on the first trigger after reset release.

## Configuration
- `ROM_FETCH_HALT_EN` defined:
  - At the HOLD handshake, `instr[DW-1:DW-OPW]` == all-ones is the halt opcode.
  - The controller enters HALT and asserts `halted`.
  - `pc` still advances (or jumps) so a resume via `jump_en` is explicit.
- Not defined:
  - No opcode is special; HALT is unreachable and `halted` is tied 0.
  - The all-ones word is fetched like any other.

## Structure
- Package `rom_fetch_pkg`: state enumeration (IDLE/FETCH/HOLD/HALT), halt-opcode constant, latency counter width (3 bits).
- Sub-module `rom_fetch_timer`:
  - Loadable down-counter with a zero flag.
  - Loaded on IDLE→FETCH, enabled in FETCH.
- Everything else lives in a single FSM plus datapath registers in `rom_fetch_ctrl`.

## Test plan
- Reset, then `run`=1, `instr_ready`=1, ROM[0..2]=0x1234,0x5678,0x9ABC, ROM_LAT=1 → `instr` = 0x1234, 0x5678, 0x9ABC with `instr_valid` pulses 4 cycles apart; `pc` ends at 3.
- `step` pulse in IDLE with `instr_ready`=0 for 5 cycles → `instr_valid` held 5+ cycles with `instr` stable; second `step` during HOLD is ignored; exactly one instruction is accepted.
- `jump_en`=1, `jump_addr`=0x3FE at the handshake of the word at 0x010 → next fetch uses `rom_addr`=0x3FE; after 0x3FF the next `rom_addr` is 0x000 (wrap).
- With `ROM_FETCH_HALT_EN`, ROM[5]=0xF000, `run`=1 → after the handshake of word 5, `halted`=1, `pc`=6, no further `instr_valid`; `jump_en` with `jump_addr`=0 → `halted`=0, fetch resumes at 0. Without the macro, 0xF000 passes through and fetching continues to 6.
- `rst` asserted while `instr_valid`=1 → `instr_valid`, `pc`, `rom_addr`, `instr` are 0 before the next clock edge; after release, the first fetch reads address 0.
- `jump_en` and `step` in the same IDLE cycle → `pc`=`jump_addr`, no fetch; next `step` fetches from `jump_addr`.
